// File: rtl/cmul_pkg.sv
// Shared definitions for the sequential complex multiplier.
//   state_t   : controller states (IDLE -> MUL -> COMB -> DONE -> IDLE)
//   op_sel_t  : which operand pair the shared adder sees this cycle
//   W_IN/W_RES, pass counts and the input-to-output latency
package cmul_pkg;

  localparam int W_IN       = 5;
  localparam int W_RES      = 10;
  localparam int MUL_STEPS  = 6;
  localparam int NUM_PROD   = 4;
  localparam int COMB_STEPS = 3;
  localparam int LATENCY    = 28;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    COMB = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    SEL_NONE = 3'd0,
    SEL_MUL  = 3'd1,  // shift-add pass of the current partial product
    SEL_C0   = 3'd2,  // P0 + ~P1
    SEL_C1   = 3'd3,  // tmp + 1  -> real part
    SEL_C2   = 3'd4   // P2 + P3  -> imaginary part
  } op_sel_t;

  // Sign-extend an operand component to the adder width.
  function automatic logic [W_RES-1:0] sext_in(input logic [W_IN-1:0] v);
    return {{(W_RES-W_IN){v[W_IN-1]}}, v};
  endfunction

endpackage

// File: rtl/adder_10bit.sv
// 10-bit ripple-carry adder; the only adder on the multiplier datapath.
//   x, y : addends
//   sum  : x + y mod 2^10 (carry-out is not needed by any pass)
module adder_10bit (
  input  logic [9:0] x,
  input  logic [9:0] y,
  output logic [9:0] sum
);

  logic [9:0] carry;

  assign carry[0] = 1'b0;

  generate
    for (genvar gi = 0; gi < 10; gi++) begin : g_fa
      assign sum[gi] = x[gi] ^ y[gi] ^ carry[gi];
      if (gi < 9) begin : g_carry
        assign carry[gi+1] = (x[gi] & y[gi]) | (carry[gi] & (x[gi] ^ y[gi]));
      end
    end
  endgenerate

endmodule

// File: rtl/cmul_seq_fsm.sv
// Controller for the sequential complex multiplier.
//   in_valid/in_ready   : operand handshake (ready only in IDLE)
//   out_valid/out_ready : result handshake (valid held in DONE until taken)
//   accept              : operand set is captured this cycle
//   op_sel              : adder operand pair for this cycle
//   step, prod_idx      : pass counter within a phase, current partial product
module cmul_seq_fsm
  import cmul_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic       out_ready,
  output logic       in_ready,
  output logic       out_valid,
  output logic       accept,
  output op_sel_t    op_sel,
  output logic [2:0] step,
  output logic [1:0] prod_idx
);

  state_t     state_reg, state_next;
  logic [2:0] step_reg, step_next;
  logic [1:0] prod_reg, prod_next;
  logic       out_valid_reg, out_valid_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      step_reg      <= 3'd0;
      prod_reg      <= 2'd0;
      out_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      step_reg      <= step_next;
      prod_reg      <= prod_next;
      out_valid_reg <= out_valid_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    step_next      = step_reg;
    prod_next      = prod_reg;
    out_valid_next = out_valid_reg;
    op_sel         = SEL_NONE;
    accept         = 1'b0;

    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          accept     = 1'b1;
          state_next = MUL;
          step_next  = 3'd0;
          prod_next  = 2'd0;
        end
      end

      MUL: begin
        op_sel = SEL_MUL;
        if (step_reg == 3'(MUL_STEPS - 1)) begin
          step_next = 3'd0;
          if (prod_reg == 2'(NUM_PROD - 1)) begin
            state_next = COMB;
          end else begin
            prod_next = prod_reg + 2'd1;
          end
        end else begin
          step_next = step_reg + 3'd1;
        end
      end

      COMB: begin
        case (step_reg)
          3'd0:    op_sel = SEL_C0;
          3'd1:    op_sel = SEL_C1;
          default: op_sel = SEL_C2;
        endcase
        if (step_reg == 3'(COMB_STEPS - 1)) begin
          step_next  = 3'd0;
          state_next = DONE;
        end else begin
          step_next = step_reg + 3'd1;
        end
      end

      DONE: begin
        // First DONE cycle raises the registered valid; results were
        // written on the final COMB pass, so they are already settled.
        if (!out_valid_reg) begin
          out_valid_next = 1'b1;
        end else if (out_ready) begin
          out_valid_next = 1'b0;
          state_next     = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = out_valid_reg;
  assign step      = step_reg;
  assign prod_idx  = prod_reg;

endmodule

// File: rtl/cmul_seq_ctrl.sv
// Sequential complex multiplier: (a+bj)(c+dj) using one shared 10-bit adder.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : operand handshake; a_re=a, a_im=b, b_re=c, b_im=d
//   out_valid / out_ready: result handshake; results held while valid
//   res_re               : ac - bd
//   res_im               : ad + bc (wraps), ovf flags its signed overflow
module cmul_seq_ctrl
  import cmul_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W_IN-1:0]    a_re,
  input  logic [W_IN-1:0]    a_im,
  input  logic [W_IN-1:0]    b_re,
  input  logic [W_IN-1:0]    b_im,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [W_RES-1:0]   res_re,
  output logic [W_RES-1:0]   res_im,
  output logic               ovf
);

  logic             accept;
  op_sel_t          op_sel;
  logic [2:0]       step;
  logic [1:0]       prod_idx;

  logic [W_IN-1:0]  a_reg, b_reg, c_reg, d_reg;
  logic [W_RES-1:0] acc_reg;
  logic [W_RES-1:0] prod_reg [NUM_PROD];
  logic [W_RES-1:0] res_re_reg, res_im_reg;
  logic             ovf_reg;

  logic [W_IN-1:0]  mcand, mplier;
  logic [W_RES-1:0] mcand_shift;
  logic [W_RES-1:0] add_x, add_y, add_sum;
  logic             store_en;

  cmul_seq_fsm u_fsm (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .out_ready (out_ready),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .accept    (accept),
    .op_sel    (op_sel),
    .step      (step),
    .prod_idx  (prod_idx)
  );

  adder_10bit u_add (
    .x   (add_x),
    .y   (add_y),
    .sum (add_sum)
  );

  // Product order: P0=a*c, P1=b*d, P2=a*d, P3=b*c.
  always_comb begin
    mcand  = a_reg;
    mplier = c_reg;
    case (prod_idx)
      2'd0: begin mcand = a_reg; mplier = c_reg; end
      2'd1: begin mcand = b_reg; mplier = d_reg; end
      2'd2: begin mcand = a_reg; mplier = d_reg; end
      default: begin mcand = b_reg; mplier = c_reg; end
    endcase
  end

  assign mcand_shift = sext_in(mcand) << step;

  // Adder operand mux. The multiplier's sign bit carries weight -16, so
  // step 4 adds the one's complement of m<<4 and step 5 adds the +1.
  always_comb begin
    add_x = '0;
    add_y = '0;
    case (op_sel)
      SEL_MUL: begin
        add_x = (step == 3'd0) ? '0 : acc_reg;
        case (step)
          3'd0, 3'd1, 3'd2, 3'd3:
            add_y = mplier[step[1:0]] ? mcand_shift : '0;
          3'd4:
            add_y = mplier[W_IN-1] ? ~mcand_shift : '0;
          default:
            add_y = mplier[W_IN-1] ? W_RES'(1) : '0;
        endcase
      end
      SEL_C0: begin
        add_x = prod_reg[0];
        add_y = ~prod_reg[1];
      end
      SEL_C1: begin
        add_x = acc_reg;
        add_y = W_RES'(1);
      end
      SEL_C2: begin
        add_x = prod_reg[2];
        add_y = prod_reg[3];
      end
      default: ;
    endcase
  end

  assign store_en = (op_sel == SEL_MUL) && (step == 3'(MUL_STEPS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg      <= '0;
      b_reg      <= '0;
      c_reg      <= '0;
      d_reg      <= '0;
      acc_reg    <= '0;
      res_re_reg <= '0;
      res_im_reg <= '0;
      ovf_reg    <= 1'b0;
    end else begin
      if (accept) begin
        a_reg <= a_re;
        b_reg <= a_im;
        c_reg <= b_re;
        d_reg <= b_im;
      end
      if (op_sel == SEL_MUL || op_sel == SEL_C0) begin
        acc_reg <= add_sum;
      end
      if (op_sel == SEL_C1) begin
        res_re_reg <= add_sum;
      end
      if (op_sel == SEL_C2) begin
        res_im_reg <= add_sum;
        // Signed overflow: operands agree in sign, sum disagrees.
        ovf_reg    <= (prod_reg[2][W_RES-1] == prod_reg[3][W_RES-1]) &&
                      (add_sum[W_RES-1] != prod_reg[2][W_RES-1]);
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_PROD; gi++) begin : g_prod
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          prod_reg[gi] <= '0;
        end else if (store_en && prod_idx == 2'(gi)) begin
          prod_reg[gi] <= add_sum;
        end
      end
    end
  endgenerate

  assign res_re = res_re_reg;
  assign res_im = res_im_reg;
  assign ovf    = ovf_reg;

endmodule

// File: tb/tb_cmul_seq_ctrl.sv
module tb_cmul_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [4:0] a_re = '0, a_im = '0, b_re = '0, b_im = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [9:0] res_re, res_im;
  logic       ovf;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  cmul_seq_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_re      (a_re),
    .a_im      (a_im),
    .b_re      (b_re),
    .b_im      (b_im),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res_re    (res_re),
    .res_im    (res_im),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Golden arithmetic model using integer math.
  function automatic void golden(input logic [4:0] a, b, c, d,
                                 output logic [9:0] re, im, output logic ov);
    int sa, sb, sc, sd, r, i;
    sa = $signed(a); sb = $signed(b); sc = $signed(c); sd = $signed(d);
    r  = sa * sc - sb * sd;
    i  = sa * sd + sb * sc;
    re = r[9:0];
    im = i[9:0];
    ov = (i > 511) || (i < -512);
  endfunction

  // Present operands at a falling edge and hold until accepted; returns at
  // the falling edge after the accept edge with in_valid dropped.
  task automatic send_op(input logic [4:0] a, b, c, d, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    a_re = a; a_im = b; b_re = c; b_im = d;
    in_valid = 1'b1;
    for (int w = 0; w < 60; w++) begin
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Counts falling edges until out_valid; -1 if it never comes.
  task automatic wait_valid(output int lat);
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b want=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
    total++; if (res_re !== 10'h000) begin bad++; $display("FAIL rst_res_re got=%h want=000", res_re); end
    total++; if (res_im !== 10'h000) begin bad++; $display("FAIL rst_res_im got=%h want=000", res_im); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL rst_ovf got=%b want=0", ovf); end
    $display("reset: in_ready=%b out_valid=%b res_re=%h res_im=%h ovf=%b",
             in_ready, out_valid, res_re, res_im, ovf);
  endtask

  task automatic test_basic;
    logic [4:0] va [3], vb [3], vc [3], vd [3];
    logic [9:0] er [3], ei [3];
    logic       eo [3];
    bit ok;
    int lat;
    va[0] = 5'd3;  vb[0] = 5'd2;  vc[0] = 5'd1;  vd[0] = 5'd4;  er[0] = 10'h3FB; ei[0] = 10'h00E; eo[0] = 1'b0;
    va[1] = 5'd15; vb[1] = 5'd15; vc[1] = 5'd15; vd[1] = 5'h10; er[1] = 10'h1D1; ei[1] = 10'h3F1; eo[1] = 1'b0;
    va[2] = 5'h10; vb[2] = 5'h10; vc[2] = 5'h10; vd[2] = 5'h10; er[2] = 10'h000; ei[2] = 10'h200; eo[2] = 1'b1;
    for (int t = 0; t < 3; t++) begin
      send_op(va[t], vb[t], vc[t], vd[t], ok);
      total++; if (!ok) begin bad++; $display("FAIL basic%0d_accept got=0 want=1", t); end
      wait_valid(lat);
      total++; if (lat !== 28) begin bad++; $display("FAIL basic%0d_latency got=%0d want=28", t, lat); end
      total++; if (res_re !== er[t]) begin bad++; $display("FAIL basic%0d_res_re got=%h want=%h", t, res_re, er[t]); end
      total++; if (res_im !== ei[t]) begin bad++; $display("FAIL basic%0d_res_im got=%h want=%h", t, res_im, ei[t]); end
      total++; if (ovf !== eo[t]) begin bad++; $display("FAIL basic%0d_ovf got=%b want=%b", t, ovf, eo[t]); end
      $display("job basic%0d: a=%h b=%h c=%h d=%h -> re=%h im=%h ovf=%b lat=%0d",
               t, va[t], vb[t], vc[t], vd[t], res_re, res_im, ovf, lat);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic%0d_valid_drop got=%b want=0", t, out_valid); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL basic%0d_ready_back got=%b want=1", t, in_ready); end
    end
  endtask

  task automatic test_stall;
    bit ok;
    int lat;
    send_op(5'd3, 5'd2, 5'd1, 5'd4, ok);
    total++; if (!ok) begin bad++; $display("FAIL stall_accept got=0 want=1"); end
    // Operands offered while busy must be ignored.
    a_re = 5'd7; a_im = 5'd9; b_re = 5'h13; b_im = 5'd5; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    wait_valid(lat);
    total++; if (lat !== 26) begin bad++; $display("FAIL stall_latency got=%0d want=26", lat); end
    for (int k = 0; k < 10; k++) begin
      in_valid = k[0];
      a_re = 5'(k); a_im = 5'(k + 3);
      @(negedge clk);
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stall%0d_valid got=%b want=1", k, out_valid); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall%0d_in_ready got=%b want=0", k, in_ready); end
      total++; if (res_re !== 10'h3FB) begin bad++; $display("FAIL stall%0d_res_re got=%h want=3fb", k, res_re); end
      total++; if (res_im !== 10'h00E) begin bad++; $display("FAIL stall%0d_res_im got=%h want=00e", k, res_im); end
    end
    in_valid = 1'b0;
    $display("job stall: re=%h im=%h ovf=%b held 10 cycles", res_re, res_im, ovf);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stall_valid_drop got=%b want=0", out_valid); end
  endtask

  task automatic test_reset_mid;
    bit ok;
    int lat;
    send_op(5'd15, 5'd15, 5'd15, 5'h10, ok);
    total++; if (!ok) begin bad++; $display("FAIL midrst_accept got=0 want=1"); end
    repeat (12) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL midrst_in_ready got=%b want=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_out_valid got=%b want=0", out_valid); end
    total++; if (res_re !== 10'h000) begin bad++; $display("FAIL midrst_res_re got=%h want=000", res_re); end
    total++; if (res_im !== 10'h000) begin bad++; $display("FAIL midrst_res_im got=%h want=000", res_im); end
    $display("reset mid-job: in_ready=%b out_valid=%b re=%h im=%h", in_ready, out_valid, res_re, res_im);
    @(negedge clk);
    rst_n = 1'b1;
    send_op(5'h10, 5'h10, 5'h10, 5'h10, ok);
    total++; if (!ok) begin bad++; $display("FAIL postrst_accept got=0 want=1"); end
    wait_valid(lat);
    total++; if (lat !== 28) begin bad++; $display("FAIL postrst_latency got=%0d want=28", lat); end
    total++; if (res_re !== 10'h000) begin bad++; $display("FAIL postrst_res_re got=%h want=000", res_re); end
    total++; if (res_im !== 10'h200) begin bad++; $display("FAIL postrst_res_im got=%h want=200", res_im); end
    total++; if (ovf !== 1'b1) begin bad++; $display("FAIL postrst_ovf got=%b want=1", ovf); end
    $display("job postrst: re=%h im=%h ovf=%b", res_re, res_im, ovf);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [4:0] oa [4], ob [4], oc [4], od [4];
    logic [9:0] er, ei;
    logic       eo;
    int lat, t_acc, t_prev;
    t_prev = 0;
    for (int j = 0; j < 4; j++) begin
      oa[j] = 5'($urandom); ob[j] = 5'($urandom);
      oc[j] = 5'($urandom); od[j] = 5'($urandom);
    end
    out_ready = 1'b1;
    @(negedge clk);
    a_re = oa[0]; a_im = ob[0]; b_re = oc[0]; b_im = od[0];
    in_valid = 1'b1;
    for (int j = 0; j < 4; j++) begin
      for (int w = 0; w < 60 && !in_ready; w++) @(negedge clk);
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b%0d_in_ready got=%b want=1", j, in_ready); end
      @(posedge clk);
      @(negedge clk);
      t_acc = cyc;
      if (j > 0) begin
        total++; if (t_acc - t_prev != 30) begin bad++; $display("FAIL b2b%0d_interval got=%0d want=30", j, t_acc - t_prev); end
      end
      t_prev = t_acc;
      if (j < 3) begin
        a_re = oa[j+1]; a_im = ob[j+1]; b_re = oc[j+1]; b_im = od[j+1];
      end else begin
        in_valid = 1'b0;
      end
      wait_valid(lat);
      golden(oa[j], ob[j], oc[j], od[j], er, ei, eo);
      total++; if (lat !== 28) begin bad++; $display("FAIL b2b%0d_latency got=%0d want=28", j, lat); end
      total++; if (res_re !== er) begin bad++; $display("FAIL b2b%0d_res_re got=%h want=%h", j, res_re, er); end
      total++; if (res_im !== ei) begin bad++; $display("FAIL b2b%0d_res_im got=%h want=%h", j, res_im, ei); end
      total++; if (ovf !== eo) begin bad++; $display("FAIL b2b%0d_ovf got=%b want=%b", j, ovf, eo); end
      $display("job b2b%0d: a=%h b=%h c=%h d=%h -> re=%h im=%h ovf=%b",
               j, oa[j], ob[j], oc[j], od[j], res_re, res_im, ovf);
    end
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_final_valid got=%b want=0", out_valid); end
    out_ready = 1'b0;
  endtask

  initial begin
    #1;
    test_reset;
    @(negedge clk);
    rst_n = 1'b1;
    test_basic;
    test_stall;
    test_reset_mid;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cmul_seq_ctrl.md
Name: cmul_seq_ctrl

Overview:
- Sequential complex multiplier: (a+bj)·(c+dj) with 5-bit two's-complement components and 10-bit two's-complement results.
- All arithmetic time-shares a single internal Adder_10bit instance, driven by a small FSM using shift-add passes.
- Sits between the operand source and the result consumer, with valid/ready handshakes on both sides.
- Area-optimised alternative to the parallel complex multiplier.

Parameters:
- W_IN, 5, operand component width (fixed; the adder is 10-bit).
- W_RES, 10, product/result width (fixed, equals the adder width).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand set valid.
- in_ready  out  1  block can accept an operand set.
- a_re  in  5  a (signed).
- a_im  in  5  b (signed).
- b_re  in  5  c (signed).
- b_im  in  5  d (signed).
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  consumer accepts the result.
- res_re  out  10  ac − bd (signed).
- res_im  out  10  ad + bc (signed, wraps mod 2^10).
- ovf  out  1  res_im overflowed; valid with out_valid.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE; accumulator and all four product registers are cleared.
  - in_ready=1, out_valid=0, res_re=0, res_im=0, ovf=0.
  - Reset mid-operation abandons the job; no result is produced.
- States: IDLE → MUL → COMB → DONE → IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, register a,b,c,d and go to MUL with prod_idx=0, step=0.
- MUL: one adder pass per clock, 6 passes per product. Products are computed in order P0=a·c, P1=b·d, P2=a·d, P3=b·c.
  - Multiplicand m is sign-extended to 10 bits; multiplier bits y[4:0]. Accumulator starts at 0 for each product.
  - step 0..3: acc ← acc + (y[i] ? m<<i : 0).
  - step 4: acc ← acc + (y[4] ? ~(m<<4) : 0), subtracting the weight −16 term.
  - step 5: acc ← acc + (y[4] ? 1 : 0); acc is then stored in P[prod_idx].
  - After P3 (24 cycles in total), go to COMB.
- COMB: 3 passes.
  - c0: tmp ← P0 + ~P1.
  - c1: res_re ← tmp + 1.
  - c2: res_im ← P2 + P3. ovf ← (P2[9]==P3[9]) && (sum[9]!=P2[9]).
  - Adder carry-out is ignored; all results wrap mod 2^10.
- DONE:
  - out_valid=1. res_re, res_im and ovf are stable while out_valid=1.
  - On out_ready, go to IDLE; out_valid drops the next cycle.
- Latency: out_valid rises exactly 28 clocks after the input-accept edge. Every pass is executed even when the multiplier bit is 0, so latency does not depend on the data.
- in_ready=0 in MUL/COMB/DONE. in_valid is ignored there and the registered operands do not change.
- After the output handshake, in_ready returns the cycle after DONE exits. Minimum issue interval is 30 cycles.
- Range limits:
  - res_re is always in [−496, 496], so it never overflows.
  - res_im overflows only for a=b=c=d=−16 (exact 512 → 0x200, ovf=1).
- Outputs are registered. No combinational path exists from in_* to out_*.

Decomposition:
- Shared package cmul_pkg holds:
  - the state enum (IDLE, MUL, COMB, DONE);
  - W_IN and W_RES;
  - MUL_STEPS=6, NUM_PROD=4, COMB_STEPS=3;
  - LATENCY=28.
- Adder_10bit is instantiated once and is the only adder; no `+` operators appear on the datapath.
- Counters (step, prod_idx) are allowed as small local increments.
- One natural sub-module: cmul_seq_fsm (state, step/prod counters, adder operand-mux select). The top holds the registers and the adder.

Test Plan:
- a=3,b=2,c=1,d=4 → after 28 clk: res_re=0x3FB (−5), res_im=0x00E (14), ovf=0.
- a=15,b=15,c=15,d=−16 → res_re=0x1D1 (465), res_im=0x3F1 (−15), ovf=0.
- a=b=c=d=−16 → res_re=0x000, res_im=0x200, ovf=1.
- Hold out_ready=0 for 10 cycles after out_valid → outputs stable and in_ready=0. Pulse new in_valid operands during busy → ignored; result unchanged.
- rst_n low at cycle 12 of a job → in_ready=1, out_valid=0, outputs 0 immediately. Next job gives a correct result.
- Random back-to-back jobs with out_ready=1 → each result matches the golden model (wrap mod 1024), and the issue interval is 30 cycles.
